operand_fetch: RTL
==================

// Module: operand_fetch
// PURPOSE
// - Decode/register-fetch stage directly upstream of the ALU. Accepts one RV32I instr + pc per handshake, reads a
//   32x32 register file and decodes alu_operation. Registers alu_a/alu_b and destination info for the execute stage.
// - Owns the architectural register file; writeback port comes from the downstream writeback stage.
// PARAMETERS
// - XLEN       32  datapath width (only 32 supported)
// - RF_DEPTH   32  number of registers; x0 hardwired to zero
// PORTS
// - clk          in   1     rising-edge clock
// - rst          in   1     asynchronous, active-high reset
// - in_valid     in   1     instr/pc valid
// - in_ready     out  1     stage can accept instr this cycle
// - instr        in   32    RV32I instruction word
// - pc           in   32    address of instr
// - wb_en        in   1     register file write enable
// - wb_rd        in   5     write address
// - wb_data      in   32    write data
// - out_valid    out  1     registered outputs valid
// - out_ready    in   1     execute stage consumes outputs
// - alu_operation out 3     000 add,001 sub,010 and,011 or,100 xor,101 sll,110 srl,111 sra
// - alu_a        out  32    first ALU operand
// - alu_b        out  32    second ALU operand
// - rd           out  5     destination register
// - rd_we        out  1     instr writes rd (forced 0 when rd==0)
// - slt_sel      out  2     00 none, 01 take signed_less_than, 10 take less_than (from ALU flags)
// - illegal      out  1     unsupported opcode
// BEHAVIOUR
// - Reset (async): out_valid=0, all outputs 0, all registers 0; in_ready=1 after reset deasserts.
// - in_ready = !out_valid | out_ready (combinational). Capture when in_valid & in_ready; latency 1 clk.
// - out_valid set on capture, cleared on out_ready with no new capture. Outputs stable while out_valid & !out_ready.
// - Decode (opcode -> op, alu_a, alu_b):
//   OP 0110011: a=rs1,b=rs2; f3 000 add/sub(f7[5]),001 sll,100 xor,101 srl/sra(f7[5]),110 or,111 and,
//     010 sub+slt_sel=01, 011 sub+slt_sel=10.
//   OP-IMM 0010011: a=rs1,b=imm_i; same map, f3 000 always add; shifts b={27'b0,instr[24:20]}, sra if instr[30].
//   LOAD 0000011: add rs1+imm_i. STORE 0100011: add rs1+imm_s, rd_we=0.
//   BRANCH 1100011: sub rs1,rs2, rd_we=0. LUI: add 0+imm_u. AUIPC: add pc+imm_u. JAL/JALR: add pc+4.
//   Other opcode: illegal=1, op=add, a=b=0, rd_we=0, slt_sel=00.
// - Immediates sign-extended from instr[31]; imm_u = {instr[31:12],12'b0}.
// - Register file: write on posedge when wb_en & wb_rd!=0; writes with wb_rd==0 dropped; reads of x0 return 0.
// - Writes proceed during stall; already-captured operands are not refreshed (hazards are the controller's job).
// - rst mid-operation discards captured instr; no write completes on a cycle where rst is high.
// CONFIGURATION
// - OPERAND_FETCH_WB_BYPASS_EN defined: capture with wb_en & wb_rd==rs & rs!=0 in same cycle uses wb_data.
// - Not defined: capture in that cycle uses the pre-write register value; write still lands.
// TESTING
// - x1=5,x2=3 via wb; add x3,x1,x2 -> next clk out_valid=1, op=000, a=5, b=3, rd=3, rd_we=1.
// - sub x4,x1,x2 with out_ready=0 for 3 clk -> outputs held, in_ready=0; out_ready=1 -> in_ready=1.
// - srai x5,x1,4 -> op=111, b=32'h4; slti x5,x1,-1 -> op=001, b=32'hFFFFFFFF, slt_sel=01.
// - wb x1=9 same cycle as capture of add x6,x1,x0 -> a=9 with BYPASS_EN, a=5 without; x1 reads 9 after.
// - wb_rd=0 wb_data=7, then add x7,x0,x0 -> a=0,b=0; opcode 7'h7F -> illegal=1, rd_we=0.
// - Assert rst while out_valid=1 -> out_valid=0 immediately, x1 reads 0 after release.

Source files
------------

// File: rtl/operand_fetch.sv
`default_nettype none
// ============================================================================
// operand_fetch : RV32I decode / register-fetch stage feeding the ALU; owns
//                 the 32x32 architectural register file.
// Optional macro : OPERAND_FETCH_WB_BYPASS_EN (same-cycle writeback bypass)
// Revision       : 1.0
// ============================================================================
module operand_fetch #(
    parameter int XLEN     = 32,
    parameter int RF_DEPTH = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     instr,
    input  logic [XLEN-1:0] pc,
    input  logic            wb_en,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [2:0]      alu_operation,
    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    output logic [4:0]      rd,
    output logic            rd_we,
    output logic [1:0]      slt_sel,
    output logic            illegal
);

    localparam logic [6:0] c_OPC_OP     = 7'b0110011;
    localparam logic [6:0] c_OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] c_OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] c_OPC_STORE  = 7'b0100011;
    localparam logic [6:0] c_OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] c_OPC_LUI    = 7'b0110111;
    localparam logic [6:0] c_OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] c_OPC_JAL    = 7'b1101111;
    localparam logic [6:0] c_OPC_JALR   = 7'b1100111;

    localparam logic [2:0] c_ALU_ADD = 3'b000;
    localparam logic [2:0] c_ALU_SUB = 3'b001;
    localparam logic [2:0] c_ALU_AND = 3'b010;
    localparam logic [2:0] c_ALU_OR  = 3'b011;
    localparam logic [2:0] c_ALU_XOR = 3'b100;
    localparam logic [2:0] c_ALU_SLL = 3'b101;
    localparam logic [2:0] c_ALU_SRL = 3'b110;
    localparam logic [2:0] c_ALU_SRA = 3'b111;

    logic [XLEN-1:0] rf_q [RF_DEPTH];

    logic            out_valid_q;
    logic [2:0]      op_q;
    logic [XLEN-1:0] a_q;
    logic [XLEN-1:0] b_q;
    logic [4:0]      rd_q;
    logic            rd_we_q;
    logic [1:0]      slt_q;
    logic            illegal_q;

    logic [2:0]      op_d;
    logic [XLEN-1:0] a_d;
    logic [XLEN-1:0] b_d;
    logic            we_d;
    logic [1:0]      slt_d;
    logic            illegal_d;

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [XLEN-1:0] rs1_val;
    logic [XLEN-1:0] rs2_val;
    logic [XLEN-1:0] imm_i;
    logic [XLEN-1:0] imm_s;
    logic [XLEN-1:0] imm_u;
    logic            capture;

    assign opcode  = instr[6:0];
    assign funct3  = instr[14:12];
    assign rs1     = instr[19:15];
    assign rs2     = instr[24:20];
    assign imm_i   = {{20{instr[31]}}, instr[31:20]};
    assign imm_s   = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_u   = {instr[31:12], 12'b0};

    assign in_ready = !out_valid_q || out_ready;
    assign capture  = in_valid && in_ready;

`ifdef OPERAND_FETCH_WB_BYPASS_EN
    // A write landing this cycle is forwarded so the captured operand is current.
    assign rs1_val = (rs1 == 5'd0) ? '0 :
                     (wb_en && (wb_rd == rs1)) ? wb_data : rf_q[rs1];
    assign rs2_val = (rs2 == 5'd0) ? '0 :
                     (wb_en && (wb_rd == rs2)) ? wb_data : rf_q[rs2];
`else
    assign rs1_val = (rs1 == 5'd0) ? '0 : rf_q[rs1];
    assign rs2_val = (rs2 == 5'd0) ? '0 : rf_q[rs2];
`endif

    function automatic logic [2:0] f_alu_op(input logic [2:0] f3,
                                            input logic       sub_en,
                                            input logic       sra_en);
        logic [2:0] op;
        case (f3)
            3'b000:  op = sub_en ? c_ALU_SUB : c_ALU_ADD;
            3'b001:  op = c_ALU_SLL;
            3'b010:  op = c_ALU_SUB;
            3'b011:  op = c_ALU_SUB;
            3'b100:  op = c_ALU_XOR;
            3'b101:  op = sra_en ? c_ALU_SRA : c_ALU_SRL;
            3'b110:  op = c_ALU_OR;
            default: op = c_ALU_AND;
        endcase
        return op;
    endfunction

    always_comb begin
        op_d      = c_ALU_ADD;
        a_d       = '0;
        b_d       = '0;
        we_d      = 1'b0;
        slt_d     = 2'b00;
        illegal_d = 1'b0;
        case (opcode)
            c_OPC_OP, c_OPC_OPIMM: begin
                a_d   = rs1_val;
                we_d  = 1'b1;
                op_d  = f_alu_op(funct3, (opcode == c_OPC_OP) && instr[30], instr[30]);
                slt_d = (funct3 == 3'b010) ? 2'b01 :
                        (funct3 == 3'b011) ? 2'b10 : 2'b00;
                if (opcode == c_OPC_OP) begin
                    b_d = rs2_val;
                end else if ((funct3 == 3'b001) || (funct3 == 3'b101)) begin
                    b_d = {27'b0, instr[24:20]};
                end else begin
                    b_d = imm_i;
                end
            end
            c_OPC_LOAD: begin
                a_d  = rs1_val;
                b_d  = imm_i;
                we_d = 1'b1;
            end
            c_OPC_STORE: begin
                a_d = rs1_val;
                b_d = imm_s;
            end
            c_OPC_BRANCH: begin
                op_d = c_ALU_SUB;
                a_d  = rs1_val;
                b_d  = rs2_val;
            end
            c_OPC_LUI: begin
                b_d  = imm_u;
                we_d = 1'b1;
            end
            c_OPC_AUIPC: begin
                a_d  = pc;
                b_d  = imm_u;
                we_d = 1'b1;
            end
            c_OPC_JAL, c_OPC_JALR: begin
                a_d  = pc;
                b_d  = XLEN'(4);
                we_d = 1'b1;
            end
            default: illegal_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            op_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            rd_q        <= '0;
            rd_we_q     <= 1'b0;
            slt_q       <= '0;
            illegal_q   <= 1'b0;
        end else if (capture) begin
            out_valid_q <= 1'b1;
            op_q        <= op_d;
            a_q         <= a_d;
            b_q         <= b_d;
            rd_q        <= instr[11:7];
            rd_we_q     <= we_d && (instr[11:7] != 5'd0);
            slt_q       <= slt_d;
            illegal_q   <= illegal_d;
        end else if (out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    // x0 is never written, so its reset value of zero persists.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < RF_DEPTH; i++) begin
                rf_q[i] <= '0;
            end
        end else if (wb_en && (wb_rd != 5'd0)) begin
            rf_q[wb_rd] <= wb_data;
        end
    end

    assign out_valid     = out_valid_q;
    assign alu_operation = op_q;
    assign alu_a         = a_q;
    assign alu_b         = b_q;
    assign rd            = rd_q;
    assign rd_we         = rd_we_q;
    assign slt_sel       = slt_q;
    assign illegal       = illegal_q;

endmodule
`default_nettype wire
